// File: rtl/merlin_imem_rsp32_if.sv
// Instruction fetch request/response bus between the prefetch unit (master)
// and the instruction memory responder (slave).
interface merlin_imem_rsp32_if;
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;

    modport master (
        input  ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        output ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i
    );

    modport slave (
        output ireqready_o, irspvalid_o, irsprerr_o, irspdata_o,
        input  ireqvalid_i, ireqhpl_i, ireqaddr_i, irspready_i
    );
endinterface

// File: rtl/merlin_imem_rsp32.sv
// Instruction-bus target: decodes fetches, reads the instruction SRAM and returns
// in-order {rerr, data} responses through a registered response FIFO.
module merlin_imem_rsp32 #(
    parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned C_MEM_ADDR_W  = 12,
    parameter int unsigned C_WAIT_CYCLES = 0,
    parameter int unsigned C_RSP_DEPTH_X = 2,
    parameter bit          C_USER_EXEC   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clk_en_i,
    merlin_imem_rsp32_if.slave      ibus,
    output logic                    mem_rd_o,
    output logic [C_MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]             mem_rdata_i
);

    localparam int unsigned DEPTH  = 1 << C_RSP_DEPTH_X;
    localparam int unsigned CNT_W  = C_RSP_DEPTH_X + 1;
    localparam int unsigned PTR_W  = C_RSP_DEPTH_X;
    localparam int unsigned NSTG   = C_WAIT_CYCLES + 1;
    localparam int unsigned TAG_LO = 2 + C_MEM_ADDR_W;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic             accept;
    logic             rsp;
    logic             req_err;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  err_q, err_d;
    logic [31:0]      s1_data;
    logic [31:0]      last_data;

    rsp_t             buf_q [DEPTH];
    rsp_t             buf_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    rsp_t             out_q, out_d;
    logic             out_vld_q, out_vld_d;
    rsp_t             push_rsp;
    logic             push, out_load, buf_empty, buf_wr, buf_rd;

    // Occupancy bounds in-flight plus buffered responses, so the FIFO cannot overflow
    assign ibus.ireqready_o = ~reset_i & (cnt_q != CNT_W'(DEPTH));
    assign accept           = ibus.ireqvalid_i & ibus.ireqready_o & clk_en_i;
    assign rsp              = out_vld_q & ibus.irspready_i & clk_en_i;

    assign req_err = (ibus.ireqaddr_i[31:TAG_LO] != C_BASE_ADDR[31:TAG_LO])
                   | (|ibus.ireqaddr_i[1:0])
                   | ((C_USER_EXEC == 1'b0) & (ibus.ireqhpl_i == 2'b00));

    assign mem_rd_o   = accept & ~req_err;
    assign mem_addr_o = ibus.ireqaddr_i[TAG_LO-1:2];

    always_comb begin
        cnt_d = cnt_q;
        if (accept & ~rsp) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp & ~accept) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stage 1 carries only {valid, err}; its data is the SRAM output, held by the SRAM
    assign s1_data = err_q[0] ? 32'h0 : mem_rdata_i;

    always_comb begin
        vld_d = vld_q;
        err_d = err_q;
        if (clk_en_i) begin
            vld_d[0] = accept;
            err_d[0] = req_err;
            for (int k = 1; k < int'(NSTG); k++) begin
                vld_d[k] = vld_q[k-1];
                err_d[k] = err_q[k-1];
            end
        end
    end

    generate
        if (C_WAIT_CYCLES == 0) begin : g_nowait
            assign last_data = s1_data;
        end else begin : g_wait
            logic [31:0] data_q [C_WAIT_CYCLES];
            logic [31:0] data_d [C_WAIT_CYCLES];

            always_comb begin
                for (int k = 0; k < int'(C_WAIT_CYCLES); k++) begin
                    data_d[k] = data_q[k];
                end
                if (clk_en_i) begin
                    data_d[0] = s1_data;
                    for (int k = 1; k < int'(C_WAIT_CYCLES); k++) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int k = 0; k < int'(C_WAIT_CYCLES); k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < int'(C_WAIT_CYCLES); k++) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end

            assign last_data = data_q[C_WAIT_CYCLES-1];
        end
    endgenerate

    assign push_rsp = {err_q[NSTG-1], last_data};

    // Output register backed by a ring buffer; empty buffer lets a new response bypass
    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        push      = clk_en_i & vld_q[NSTG-1];
        out_load  = clk_en_i & (~out_vld_q | rsp);
        buf_empty = (buf_cnt_q == '0);
        buf_rd    = out_load & ~buf_empty;
        buf_wr    = push & ~(out_load & buf_empty);
        if (out_load) begin
            out_vld_d = ~buf_empty | push;
            if (!buf_empty) begin
                out_d = buf_q[rd_ptr_q];
            end else if (push) begin
                out_d = push_rsp;
            end
        end
        if (buf_wr) begin
            buf_d[wr_ptr_q] = push_rsp;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (buf_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        buf_cnt_d = buf_cnt_q + CNT_W'(buf_wr) - CNT_W'(buf_rd);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            vld_q     <= '0;
            err_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            buf_cnt_q <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            buf_cnt_q <= buf_cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign ibus.irspvalid_o = out_vld_q;
    assign ibus.irsprerr_o  = out_q.err;
    assign ibus.irspdata_o  = out_q.data;

endmodule

// File: tb/tb_merlin_imem_rsp32.sv
// Bench for merlin_imem_rsp32: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the responder.
module tb_merlin_imem_rsp32;

    localparam int unsigned AW    = 12;
    localparam int unsigned WAIT  = 0;
    localparam int unsigned DX    = 2;
    localparam int unsigned DEPTH = 1 << DX;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = 32'h0;
    logic [31:0]   sram [1 << AW];

    int checks = 0;
    int errors = 0;

    merlin_imem_rsp32_if ibus ();

    merlin_imem_rsp32 #(
        .C_BASE_ADDR  (BASE),
        .C_MEM_ADDR_W (AW),
        .C_WAIT_CYCLES(WAIT),
        .C_RSP_DEPTH_X(DX),
        .C_USER_EXEC  (1'b0)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .clk_en_i   (clk_en),
        .ibus       (ibus),
        .mem_rd_o   (mem_rd),
        .mem_addr_o (mem_addr),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data appears the cycle after the strobe and is held
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned rt;
    } exp_t;

    exp_t        q[$];
    int unsigned t = 0;

    function automatic logic req_err(input logic [31:0] a, input logic [1:0] h);
        return ((a >> (AW + 2)) != (BASE >> (AW + 2))) || (a[1:0] != 2'b00) || (h == 2'b00);
    endfunction

    function automatic logic m_ready();
        return !rst && (q.size() != DEPTH);
    endfunction

    function automatic logic m_valid();
        return (q.size() != 0) && (q[0].rt <= t);
    endfunction

    // Time advances only on enabled edges; a response is visible 1+WAIT enabled edges after its accept
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (clk_en) begin
            logic do_rsp;
            logic do_acc;
            exp_t e;
            do_rsp = m_valid() && ibus.irspready_i;
            do_acc = ibus.ireqvalid_i && m_ready();
            t++;
            if (do_rsp) void'(q.pop_front());
            if (do_acc) begin
                e.err  = req_err(ibus.ireqaddr_i, ibus.ireqhpl_i);
                e.data = e.err ? 32'h0 : sram[ibus.ireqaddr_i[AW+1:2]];
                e.rt   = t + 1 + WAIT;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rd;
        chk("ireqready", 32'(ibus.ireqready_o), 32'(m_ready()));
        chk("irspvalid", 32'(ibus.irspvalid_o), 32'(m_valid()));
        if (m_valid()) begin
            chk("irsprerr", 32'(ibus.irsprerr_o), 32'(q[0].err));
            chk("irspdata", ibus.irspdata_o, q[0].data);
        end
        exp_rd = clk_en && ibus.ireqvalid_i && m_ready() && !req_err(ibus.ireqaddr_i, ibus.ireqhpl_i);
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(ibus.ireqaddr_i[AW+1:2]));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] h,
                         input logic rr, input logic en);
        @(posedge clk);
        #1;
        ibus.ireqvalid_i = v;
        ibus.ireqaddr_i  = a;
        ibus.ireqhpl_i   = h;
        ibus.irspready_i = rr;
        clk_en           = en;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int unsigned kind;
        kind = $urandom_range(0, 9);
        a    = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
        if (kind == 0) a = a | (32'($urandom_range(1, 255)) << (AW + 2));
        else if (kind == 1) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
        sram[4] = 32'h1234_5678;
        sram[8] = 32'hCAFE_F00D;
        rst = 1'b1;
        clk_en = 1'b1;
        ibus.ireqvalid_i = 1'b0;
        ibus.ireqaddr_i  = 32'h0;
        ibus.ireqhpl_i   = 2'b11;
        ibus.irspready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ibus.ireqready_o), 32'd1);
        chk("rst_valid", 32'(ibus.irspvalid_o), 32'd0);
        chk("rst_data", ibus.irspdata_o, 32'd0);
        chk("rst_rerr", 32'(ibus.irsprerr_o), 32'd0);

        // Single good fetch, two-cycle latency
        drive(1'b1, 32'h10, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("fetch_rd", 32'(mem_rd), 32'd1);
        chk("fetch_addr", 32'(mem_addr), 32'd4);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("fetch_early", 32'(ibus.irspvalid_o), 32'd0);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("fetch_valid", 32'(ibus.irspvalid_o), 32'd1);
        chk("fetch_data", ibus.irspdata_o, 32'h1234_5678);
        chk("fetch_rerr", 32'(ibus.irsprerr_o), 32'd0);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("fetch_done", 32'(ibus.irspvalid_o), 32'd0);

        // Range and alignment errors
        drive(1'b1, 32'h4000, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("range_nord", 32'(mem_rd), 32'd0);
        drive(1'b1, 32'h12, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("align_nord", 32'(mem_rd), 32'd0);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("range_rerr", 32'(ibus.irsprerr_o), 32'd1);
        chk("range_data", ibus.irspdata_o, 32'd0);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("align_rerr", 32'(ibus.irsprerr_o), 32'd1);
        chk("align_data", ibus.irspdata_o, 32'd0);

        // Privilege: user fetch errors, machine fetch to the same word succeeds
        drive(1'b1, 32'h20, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        chk("priv_nord", 32'(mem_rd), 32'd0);
        drive(1'b1, 32'h20, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("priv_ok_rd", 32'(mem_rd), 32'd1);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("priv_rerr", 32'(ibus.irsprerr_o), 32'd1);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("priv_ok_rerr", 32'(ibus.irsprerr_o), 32'd0);
        chk("priv_ok_data", ibus.irspdata_o, 32'hCAFE_F00D);

        // Backpressure: four accepts fill the responder
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 2'b11, 1'b0, 1'b1);
            @(negedge clk);
            if (k >= 4) chk("bp_full", 32'(ibus.ireqready_o), 32'd0);
        end
        drive(1'b1, 32'h200, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_still_full", 32'(ibus.ireqready_o), 32'd0);
        chk("bp_head_data", ibus.irspdata_o, sram[64]);
        drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_reopen", 32'(ibus.ireqready_o), 32'd1);
        repeat (8) drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);

        // Reset with three outstanding requests
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h300 + 32'(4 * k), 2'b11, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 2'b11, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(ibus.irspvalid_o), 32'd0);
        chk("rst_mid_ready", 32'(ibus.ireqready_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ibus.irspready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
            @(negedge clk);
            chk("post_rst_valid", 32'(ibus.irspvalid_o), 32'd0);
            chk("post_rst_ready", 32'(ibus.ireqready_o), 32'd1);
        end

        // Streaming with clock enable toggling every cycle
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 9) < 8), rand_addr(), 2'($urandom_range(0, 3)),
                  1'b1, 1'(i % 2 == 0));

        // Fully random traffic
        for (int i = 0; i < 2500; i++)
            drive(1'($urandom_range(0, 9) < 6), rand_addr(), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8));

        repeat (20) drive(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
